// File: rtl/crc_stream_engine.sv
// Streaming CRC engine: runtime width/poly/init/reflect/xorout, DATA_W-bit beats
// over valid/ready, BITS_PER_CYCLE LFSR steps per clock, one-cycle result pulse.
module crc_stream_engine #(
  parameter int MAX_BITS       = 64,
  parameter int MAX_BIT_COUNT  = 6,
  parameter int DATA_W         = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_load,
  input  logic [MAX_BIT_COUNT-1:0] crc_width_m1,
  input  logic [MAX_BITS-1:0]      poly,
  input  logic [MAX_BITS-1:0]      init,
  input  logic [MAX_BITS-1:0]      xorout,
  input  logic                     refin,
  input  logic                     refout,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_last,
  output logic                     crc_valid,
  output logic [MAX_BITS-1:0]      crc_out,
  output logic                     busy
);
  localparam int STEPS = DATA_W / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(STEPS + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  if (DATA_W % BITS_PER_CYCLE != 0) begin : g_bpc_err
    $error("DATA_W must be a multiple of BITS_PER_CYCLE");
  end

  // Loop form keeps width_m1 == MAX_BITS-1 free of shift overflow.
  function automatic logic [MAX_BITS-1:0] width_mask(input logic [MAX_BIT_COUNT-1:0] wm1);
    width_mask = '0;
    for (int i = 0; i < MAX_BITS; i++)
      if (i <= int'(wm1)) width_mask[i] = 1'b1;
  endfunction

  function automatic logic [MAX_BITS-1:0] reflect(input logic [MAX_BITS-1:0] s,
                                                  input logic [MAX_BIT_COUNT-1:0] wm1);
    reflect = '0;
    for (int i = 0; i < MAX_BITS; i++)
      if (i <= int'(wm1)) reflect[i] = s[int'(wm1) - i];
  endfunction

  logic [1:0]               fsm;
  logic [MAX_BIT_COUNT-1:0] width_q;
  logic [MAX_BITS-1:0]      poly_q, init_q, xorout_q, state_q;
  logic                     refin_q, refout_q, last_q;
  logic [DATA_W-1:0]        sbuf_q, data_rev;
  logic [CNT_W-1:0]         cnt_q;
  logic [MAX_BITS-1:0]      mask, poly_m, nxt, crc_fin;

  assign mask     = width_mask(width_q);
  assign poly_m   = poly_q & mask;
  assign in_ready = (fsm == IDLE) & ~cfg_load;
  assign busy     = (fsm != IDLE);

  always_comb begin
    data_rev = '0;
    for (int i = 0; i < DATA_W; i++) data_rev[i] = in_data[DATA_W-1-i];
  end

  // Bits are always consumed from the top of the shift buffer.
  always_comb begin
    nxt = state_q;
    for (int i = 0; i < BITS_PER_CYCLE; i++)
      nxt = ((nxt << 1) & mask) ^ ((nxt[width_q] ^ sbuf_q[DATA_W-1-i]) ? poly_m : '0);
  end

  assign crc_fin = ((refout_q ? reflect(nxt, width_q) : nxt) ^ xorout_q) & mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm       <= IDLE;
      width_q   <= '0;
      poly_q    <= '0;
      init_q    <= '0;
      xorout_q  <= '0;
      refin_q   <= 1'b0;
      refout_q  <= 1'b0;
      state_q   <= '0;
      sbuf_q    <= '0;
      last_q    <= 1'b0;
      cnt_q     <= '0;
      crc_valid <= 1'b0;
      crc_out   <= '0;
    end else if (cfg_load) begin
      width_q   <= crc_width_m1;
      poly_q    <= poly;
      init_q    <= init;
      xorout_q  <= xorout;
      refin_q   <= refin;
      refout_q  <= refout;
      state_q   <= init & width_mask(crc_width_m1);
      fsm       <= IDLE;
      crc_valid <= 1'b0;
      crc_out   <= '0;
    end else begin
      crc_valid <= 1'b0;
      case (fsm)
        IDLE: if (in_valid) begin
          sbuf_q <= refin_q ? data_rev : in_data;
          last_q <= in_last;
          cnt_q  <= CNT_W'(STEPS);
          fsm    <= SHIFT;
        end
        SHIFT: begin
          state_q <= nxt;
          sbuf_q  <= sbuf_q << BITS_PER_CYCLE;
          cnt_q   <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            if (last_q) begin
              fsm       <= DONE;
              crc_out   <= crc_fin;
              crc_valid <= 1'b1;
            end else begin
              fsm <= IDLE;
            end
          end
        end
        DONE: begin
          state_q <= init_q & mask;
          fsm     <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_crc_stream_engine.sv
// Scoreboard bench: two engines (1 and 8 bits/clock) fed identical frames;
// a negedge monitor pops expected CRCs and checks pulse latency and beat period.
module tb_crc_stream_engine;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        cfg_load;
  logic [5:0]  crc_width_m1;
  logic [63:0] poly, init, xorout;
  logic        refin, refout;
  logic        in_valid[2];
  logic [7:0]  in_data[2];
  logic        in_last[2];
  logic        in_ready[2], crc_valid[2], busy[2];
  logic [63:0] crc_out[2];

  crc_stream_engine #(.BITS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .crc_width_m1(crc_width_m1),
    .poly(poly), .init(init), .xorout(xorout), .refin(refin), .refout(refout),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .in_last(in_last[0]), .crc_valid(crc_valid[0]), .crc_out(crc_out[0]), .busy(busy[0]));

  crc_stream_engine #(.BITS_PER_CYCLE(8)) u_dut8 (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .crc_width_m1(crc_width_m1),
    .poly(poly), .init(init), .xorout(xorout), .refin(refin), .refout(refout),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .in_last(in_last[1]), .crc_valid(crc_valid[1]), .crc_out(crc_out[1]), .busy(busy[1]));

  int          tests = 0, fails = 0;
  int          cyc = 0;
  bit          gaps = 0;
  logic [7:0]  frame[$];
  logic [63:0] exp_q0[$], exp_q1[$];
  int          per[2] = '{9, 2};
  int          last_acc[2], prev_acc[2];
  bit          in_frame[2], hold_chk[2];
  logic [63:0] held[2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference: textbook bitwise CRC over the frame bytes.
  function automatic logic [63:0] model(input int w, input logic [63:0] p, input logic [63:0] ini,
                                        input logic [63:0] xo, input bit ri, input bit ro);
    logic [63:0] m, r, o;
    m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    r = ini & m;
    foreach (frame[j]) begin
      for (int i = 0; i < 8; i++) begin
        logic b, top;
        b   = ri ? frame[j][i] : frame[j][7-i];
        top = r[w-1];
        r   = (r << 1) & m;
        if (top ^ b) r = r ^ (p & m);
      end
    end
    if (ro) begin
      o = '0;
      for (int i = 0; i < w; i++) o[i] = r[w-1-i];
      r = o;
    end
    return (r ^ xo) & m;
  endfunction

  always @(negedge clk) begin
    logic [63:0] e;
    for (int k = 0; k < 2; k++) begin
      if (rst || cfg_load) begin
        in_frame[k] = 0;
        hold_chk[k] = 0;
      end else begin
        if (hold_chk[k] && !crc_valid[k]) chk($sformatf("crc_hold_dut%0d", k), crc_out[k], held[k]);
        hold_chk[k] = 0;
        if (in_valid[k] && in_ready[k]) begin
          if (in_frame[k] && !gaps)
            chk($sformatf("beat_period_dut%0d", k), 64'(cyc - prev_acc[k]), 64'(per[k]));
          prev_acc[k] = cyc;
          in_frame[k] = !in_last[k];
          if (in_last[k]) last_acc[k] = cyc;
        end
        if (crc_valid[k]) begin
          chk($sformatf("valid_latency_dut%0d", k), 64'(cyc - last_acc[k]), 64'(per[k]));
          if ((k == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_crc_valid dut%0d: got crc_out %h expected no pulse", k, crc_out[k]);
          end else begin
            e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            chk($sformatf("crc_dut%0d", k), crc_out[k], e);
          end
          held[k] = crc_out[k];
          hold_chk[k] = 1;
        end
      end
    end
  end

  // All drives happen 1 time unit after a rising edge.
  task automatic configure(input int w, input logic [63:0] p, input logic [63:0] ini,
                           input logic [63:0] xo, input bit ri, input bit ro);
    crc_width_m1 = 6'(w - 1); poly = p; init = ini; xorout = xo; refin = ri; refout = ro;
    cfg_load = 1'b1;
    @(posedge clk); #1;
    cfg_load = 1'b0;
    // Scramble the inputs: the engine must only use its latched copy.
    crc_width_m1 = 6'($urandom); poly = {$urandom, $urandom}; init = {$urandom, $urandom};
    xorout = {$urandom, $urandom}; refin = 1'($urandom); refout = 1'($urandom);
  endtask

  task automatic send_beat(input int k, input logic [7:0] d, input bit l);
    int n = 0;
    if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    in_valid[k] = 1'b1; in_data[k] = d; in_last[k] = l;
    forever begin
      @(negedge clk);
      if (in_ready[k]) break;
      n++;
      if (n > 200) begin
        tests++; fails++;
        $display("FAIL accept_timeout dut%0d: got no in_ready expected within 200 cycles", k);
        in_valid[k] = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
  endtask

  task automatic send_frame(input int k, input int nbeats);
    for (int j = 0; j < nbeats; j++) send_beat(k, frame[j], j == frame.size() - 1);
  endtask

  task automatic send_both(input int nbeats);
    fork
      send_frame(0, nbeats);
      send_frame(1, nbeats);
    join
  endtask

  task automatic expect_both(input logic [63:0] v);
    exp_q0.push_back(v);
    exp_q1.push_back(v);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 300) begin
      @(posedge clk); n++;
    end
    #1;
    tests++;
    if (n >= 300) begin
      fails++;
      $display("FAIL drain_timeout: got %0d/%0d pending expected 0/0", exp_q0.size(), exp_q1.size());
      exp_q0.delete(); exp_q1.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic std_frame();
    frame.delete();
    for (int i = 0; i < 9; i++) frame.push_back(8'(8'h31 + i));
  endtask

  task automatic run_std(input int w, input logic [63:0] p, input logic [63:0] ini,
                         input logic [63:0] xo, input bit ri, input bit ro, input logic [63:0] v);
    configure(w, p, ini, xo, ri, ro);
    expect_both(v);
    send_both(frame.size());
    drain();
  endtask

  initial begin
    rst = 1'b1; cfg_load = 1'b0; crc_width_m1 = '0; poly = '0; init = '0; xorout = '0;
    refin = 1'b0; refout = 1'b0;
    for (int k = 0; k < 2; k++) begin in_valid[k] = 1'b0; in_data[k] = '0; in_last[k] = 1'b0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("reset_crc_out", crc_out[k], 64'h0);
      chk("reset_crc_valid", 64'(crc_valid[k]), 64'h0);
      chk("reset_busy", 64'(busy[k]), 64'h0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", 64'({in_ready[0], in_ready[1]}), 64'h3);
    @(posedge clk); #1;

    std_frame();
    run_std(8,  64'h07,       64'h0,    64'h0, 0, 0, 64'hF4);
    run_std(16, 64'h1021,     64'hFFFF, 64'h0, 0, 0, 64'h29B1);
    run_std(16, 64'h8005,     64'h0,    64'h0, 1, 1, 64'hBB3D);
    run_std(32, 64'h04C11DB7, 64'hFFFFFFFF, 64'hFFFFFFFF, 1, 1, 64'hCBF43926);

    // Back-to-back frames exercise the init reload after DONE.
    configure(32, 64'h04C11DB7, 64'hFFFFFFFF, 64'hFFFFFFFF, 1, 1);
    expect_both(64'hCBF43926); expect_both(64'hCBF43926);
    fork
      begin send_frame(0, 9); send_frame(0, 9); end
      begin send_frame(1, 9); send_frame(1, 9); end
    join
    drain();

    run_std(64, 64'h42F0E1EBA9EA3693, 64'h0, 64'h0, 0, 0, 64'h6C40DF5F0B497347);

    // Abort after 4 beats: no pulse, cleared result, next frame correct.
    configure(32, 64'h04C11DB7, 64'hFFFFFFFF, 64'hFFFFFFFF, 1, 1);
    send_both(4);
    configure(32, 64'h04C11DB7, 64'hFFFFFFFF, 64'hFFFFFFFF, 1, 1);
    chk("abort_crc_out_dut1", crc_out[0], 64'h0);
    chk("abort_crc_out_dut8", crc_out[1], 64'h0);
    expect_both(64'hCBF43926);
    send_both(9);
    drain();

    // Asynchronous reset with the 1-bit/clock engine mid-SHIFT.
    send_both(1);
    rst = 1'b1;
    #1;
    chk("rst_async_crc_out_dut1", crc_out[0], 64'h0);
    chk("rst_async_crc_out_dut8", crc_out[1], 64'h0);
    chk("rst_async_busy_dut1", 64'(busy[0]), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready_dut1", 64'(in_ready[0]), 64'h1);
    chk("rst_in_ready_dut8", 64'(in_ready[1]), 64'h1);
    @(posedge clk); #1;
    run_std(8, 64'h07, 64'h0, 64'h0, 0, 0, 64'hF4);

    // Randomised configurations and frames against the reference model.
    for (int t = 0; t < 14; t++) begin
      int          w;
      logic [63:0] p, ini, xo;
      bit          ri, ro;
      w   = (t == 0) ? 64 : int'($urandom_range(1, 64));
      p   = {$urandom, $urandom}; ini = {$urandom, $urandom}; xo = {$urandom, $urandom};
      ri  = 1'($urandom); ro = 1'($urandom);
      gaps = 1'($urandom);
      frame.delete();
      repeat ($urandom_range(1, 6)) frame.push_back(8'($urandom));
      configure(w, p, ini, xo, ri, ro);
      expect_both(model(w, p, ini, xo, ri, ro));
      send_both(frame.size());
      drain();
    end
    gaps = 0;

    chk("scoreboard_empty", 64'(exp_q0.size() + exp_q1.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
